// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WTHRU
  } state_e;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  // Expands a per-lane byte enable into a bit mask over the full word.
  function automatic logic [LANES*BYTE_W-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [LANES*BYTE_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and backing-memory signals of the data cache; slave = cache, master = CPU + memory.
interface data_cache_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                             Req;
  logic                             WE;
  logic [data_cache_pkg::LANES-1:0] ByteEn;
  logic [DATA_WIDTH-1:0]            A;
  logic [DATA_WIDTH-1:0]            WD;
  logic [DATA_WIDTH-1:0]            RD;
  logic                             Stall;

  logic                             MemReq;
  logic                             MemWE;
  logic [DATA_WIDTH-1:0]            MemAddr;
  logic [DATA_WIDTH-1:0]            MemWD;
  logic [data_cache_pkg::LANES-1:0] MemBE;
  logic                             MemAck;
  logic [DATA_WIDTH-1:0]            MemRD;

  modport slave (
    input  Req, WE, ByteEn, A, WD, MemAck, MemRD,
    output RD, Stall, MemReq, MemWE, MemAddr, MemWD, MemBE
  );

  modport master (
    output Req, WE, ByteEn, A, WD, MemAck, MemRD,
    input  RD, Stall, MemReq, MemWE, MemAddr, MemWD, MemBE
  );

endinterface

// File: rtl/data_cache_array.sv
// Tag/data/valid storage: one combinational read port, one byte-enabled write port.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int SETS       = 16,
  parameter  int TAG_W      = 26,
  localparam int IDX_W      = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [LANES-1:0]      wr_be,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] line_d;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
  assign mask     = lane_mask(wr_be);

  always_comb begin
    line_d  = (data_q[wr_idx] & ~mask) | (wr_data & mask);
    valid_d = valid_q;
    if (wr_en && wr_fill) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= line_d;
      if (wr_fill) tag_q[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  data_cache_if.slave bus
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [LANES-1:0]      mem_be_q, mem_be_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  mem_ack;
  logic                  stall_c;
  logic                  wr_en, wr_fill;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  assign idx     = bus.A[2+IDX_W-1:2];
  assign tag     = bus.A[DATA_WIDTH-1:2+IDX_W];
  assign hit     = rd_valid && (rd_tag == tag);
  assign mem_ack = bus.MemAck && mem_req_q;

  data_cache_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .SETS      (SETS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_fill (wr_fill),
    .wr_idx  (idx),
    .wr_be   (wr_be),
    .wr_tag  (tag),
    .wr_data (wr_data)
  );

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_be_d   = mem_be_q;
    stall_c    = 1'b0;
    wr_en      = 1'b0;
    wr_fill    = 1'b0;
    wr_be      = '0;
    wr_data    = bus.WD;
    case (state_q)
      IDLE: begin
        if (bus.Req && bus.WE) begin
          stall_c    = 1'b1;
          state_d    = WTHRU;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = bus.A;
          mem_wd_d   = bus.WD;
          mem_be_d   = bus.ByteEn;
        end else if (bus.Req && !hit) begin
          stall_c    = 1'b1;
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {bus.A[DATA_WIDTH-1:2], 2'b00};
          mem_wd_d   = '0;
          mem_be_d   = '0;
        end
      end
      FILL: begin
        // Stall stays high through the ack; the held load hits on the next cycle.
        stall_c = 1'b1;
        if (mem_ack) begin
          wr_en      = 1'b1;
          wr_fill    = 1'b1;
          wr_be      = '1;
          wr_data    = bus.MemRD;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end
      end
      WTHRU: begin
        stall_c = !mem_ack;
        if (mem_ack) begin
          wr_en      = hit;
          wr_be      = bus.ByteEn;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
          mem_wd_d   = '0;
          mem_be_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_be_q   <= mem_be_d;
    end
  end

  assign bus.Stall   = stall_c && rst_n;
  assign bus.RD      = (state_q == IDLE && hit) ? rd_data : '0;
  assign bus.MemReq  = mem_req_q;
  assign bus.MemWE   = mem_we_q;
  assign bus.MemAddr = mem_addr_q;
  assign bus.MemWD   = mem_wd_q;
  assign bus.MemBE   = mem_be_q;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        fill_done_q, fill_done_d;
  logic        load_idle;

  assign load_idle = (state_q == IDLE) && bus.Req && !bus.WE;

  // The hit that completes a refill belongs to the miss already counted.
  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_done_d = (state_q == FILL) && mem_ack;
    if (load_idle && hit && !fill_done_q) hit_cnt_d  = hit_cnt_q + 32'd1;
    if (load_idle && !hit)                miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: plays CPU and backing memory, scoreboards load data.
module tb_data_cache;

  typedef struct {
    bit          timeout;
    int          stalls;
    int          mreqs;
    logic [31:0] rd;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mbe;
    bit          stable;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_checks;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [bit [31:0]];

  data_cache_if #(.DATA_WIDTH(32)) bus ();

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(
    .DATA_WIDTH(32),
    .SETS      (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DATA_CACHE_STATS_EN
    ,
    .HitCount (hit_count),
    .MissCount(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rd(input logic [31:0] addr);
    bit [31:0] w;
    w = {addr[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Drives one CPU access and acts as memory, acking on the ack_dly-th MemReq cycle.
  task automatic do_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wd, input int ack_dly, output obs_t o);
    bit        done;
    int        cyc;
    bit [31:0] w;
    logic [31:0] v;
    o = '{timeout: 1'b0, stalls: 0, mreqs: 0, rd: '0, mwe: 1'b0, maddr: '0,
          mwd: '0, mbe: '0, stable: 1'b1};
    w = {addr[31:2], 2'b00};
    bus.Req = 1'b1; bus.WE = we; bus.ByteEn = be; bus.A = addr; bus.WD = wd;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (bus.MemReq) begin
        o.mreqs++;
        if (o.mreqs == 1) begin
          o.mwe = bus.MemWE; o.maddr = bus.MemAddr; o.mwd = bus.MemWD; o.mbe = bus.MemBE;
        end else if (bus.MemAddr !== o.maddr || bus.MemWD !== o.mwd || bus.MemBE !== o.mbe) begin
          o.stable = 1'b0;
        end
        if (o.mreqs == ack_dly) begin
          bus.MemAck = 1'b1;
          bus.MemRD  = bus.MemWE ? 32'h5A5A5A5A : ref_rd(bus.MemAddr);
          if (bus.MemWE) begin
            v = ref_rd(bus.MemAddr);
            for (int i = 0; i < 4; i++) if (bus.MemBE[i]) v[i*8 +: 8] = bus.MemWD[i*8 +: 8];
            ref_mem[{bus.MemAddr[31:2], 2'b00}] = v;
          end
        end
      end
      #1;
      if (bus.Stall) o.stalls++;
      else begin
        done = 1'b1;
        o.rd = bus.RD;
      end
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      cyc++;
    end
    o.timeout = !done;
    bus.Req = 1'b0; bus.WE = 1'b0; bus.ByteEn = 4'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.Stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", bus.Stall); else n_pass++;
    n_checks++; if (bus.MemReq !== 1'b0) $display("FAIL rst_memreq: got %b expected 0", bus.MemReq); else n_pass++;
    n_checks++; if (bus.MemWE !== 1'b0) $display("FAIL rst_memwe: got %b expected 0", bus.MemWE); else n_pass++;
    n_checks++; if ({bus.MemAddr, bus.MemWD, bus.MemBE} !== 68'h0)
      $display("FAIL rst_membus: got %h %h %h expected zeros", bus.MemAddr, bus.MemWD, bus.MemBE); else n_pass++;
    n_checks++; if (bus.RD !== 32'h0) $display("FAIL rst_rd: got %h expected 0", bus.RD); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.Stall !== 1'b0 || bus.MemReq !== 1'b0)
      $display("FAIL post_rst_idle: got stall=%b memreq=%b expected 0 0", bus.Stall, bus.MemReq); else n_pass++;
`ifdef DATA_CACHE_STATS_EN
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0)
      $display("FAIL rst_stats: got %0d/%0d expected 0/0", hit_count, miss_count); else n_pass++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_cold_fill;
    obs_t o;
    logic [31:0] e;
    exp_q.push_back(ref_rd(32'h100));
    do_access(1'b0, 4'hF, 32'h100, 32'h0, 3, o);
    n_checks++; if (o.timeout || o.stalls != 4) $display("FAIL cold_stall: got %0d expected 4", o.stalls); else n_pass++;
    n_checks++; if (o.mreqs != 3 || o.mwe !== 1'b0)
      $display("FAIL cold_memreq: got %0d cycles we=%b expected 3 cycles we=0", o.mreqs, o.mwe); else n_pass++;
    n_checks++; if (o.maddr !== 32'h100) $display("FAIL cold_addr: got %h expected 00000100", o.maddr); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (o.rd !== e) $display("FAIL cold_rd: got %h expected %h", o.rd, e); else n_pass++;
  endtask

  task automatic test_load_hit;
    obs_t o;
    logic [31:0] e;
    exp_q.push_back(ref_rd(32'h100));
    do_access(1'b0, 4'hF, 32'h100, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.stalls != 0 || o.mreqs != 0)
      $display("FAIL hit_nomem: got stalls=%0d memreq=%0d expected 0 0", o.stalls, o.mreqs); else n_pass++;
    n_checks++; if (o.rd !== e) $display("FAIL hit_rd: got %h expected %h", o.rd, e); else n_pass++;
`ifdef DATA_CACHE_STATS_EN
    n_checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1)
      $display("FAIL stats: got hit=%0d miss=%0d expected 1 1", hit_count, miss_count); else n_pass++;
`endif
    exp_q.push_back(ref_rd(32'h103));
    do_access(1'b0, 4'hF, 32'h103, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 0 || o.rd !== e)
      $display("FAIL hit_unaligned: got rd=%h memreq=%0d expected %h 0", o.rd, o.mreqs, e); else n_pass++;
  endtask

  task automatic test_store;
    obs_t o;
    logic [31:0] e;
    do_access(1'b1, 4'b0010, 32'h101, 32'h0000AA00, 2, o);
    n_checks++; if (o.timeout || o.stalls != 2) $display("FAIL st_stall: got %0d expected 2", o.stalls); else n_pass++;
    n_checks++; if (o.mwe !== 1'b1 || o.mbe !== 4'b0010)
      $display("FAIL st_we_be: got we=%b be=%b expected 1 0010", o.mwe, o.mbe); else n_pass++;
    n_checks++; if (o.maddr !== 32'h101 || o.mwd !== 32'h0000AA00 || !o.stable)
      $display("FAIL st_addr_wd: got %h %h stable=%b expected 00000101 0000aa00 1", o.maddr, o.mwd, o.stable); else n_pass++;
    exp_q.push_back(32'hDEADAAEF);
    do_access(1'b0, 4'hF, 32'h100, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 0 || o.rd !== e)
      $display("FAIL st_merge: got rd=%h memreq=%0d expected %h 0", o.rd, o.mreqs, e); else n_pass++;
    // Store miss must not allocate: the following load still goes to memory.
    do_access(1'b1, 4'hF, 32'h108, 32'h11223344, 1, o);
    n_checks++; if (o.timeout || o.stalls != 1 || o.mwe !== 1'b1 || o.mbe !== 4'hF)
      $display("FAIL st_miss: got stalls=%0d we=%b be=%b expected 1 1 1111", o.stalls, o.mwe, o.mbe); else n_pass++;
    exp_q.push_back(ref_rd(32'h108));
    do_access(1'b0, 4'hF, 32'h108, 32'h0, 2, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 2 || o.rd !== e)
      $display("FAIL no_alloc: got rd=%h memreq=%0d expected %h 2", o.rd, o.mreqs, e); else n_pass++;
  endtask

  task automatic test_conflict;
    obs_t o;
    logic [31:0] e;
    exp_q.push_back(ref_rd(32'h140));
    do_access(1'b0, 4'hF, 32'h140, 32'h0, 2, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.stalls != 3 || o.mreqs != 2 || o.maddr !== 32'h140)
      $display("FAIL conf_fill: got stalls=%0d memreq=%0d addr=%h expected 3 2 00000140", o.stalls, o.mreqs, o.maddr); else n_pass++;
    n_checks++; if (o.rd !== e) $display("FAIL conf_rd: got %h expected %h", o.rd, e); else n_pass++;
    exp_q.push_back(ref_rd(32'h100));
    do_access(1'b0, 4'hF, 32'h100, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 1 || o.rd !== e)
      $display("FAIL conf_evict: got rd=%h memreq=%0d expected %h 1", o.rd, o.mreqs, e); else n_pass++;
  endtask

  task automatic test_back_to_back;
    obs_t o;
    logic [31:0] e;
    logic [31:0] addrs [4];
    addrs = '{32'h100, 32'h108, 32'h102, 32'h10B};
    foreach (addrs[i]) exp_q.push_back(ref_rd(addrs[i]));
    foreach (addrs[i]) begin
      do_access(1'b0, 4'hF, addrs[i], 32'h0, 1, o);
      e = exp_q.pop_front();
      n_checks++; if (o.timeout || o.mreqs != 0 || o.stalls != 0 || o.rd !== e)
        $display("FAIL b2b_%0d: got rd=%h memreq=%0d stalls=%0d expected %h 0 0", i, o.rd, o.mreqs, o.stalls, e); else n_pass++;
    end
  endtask

  task automatic test_ack_ignored;
    bus.MemAck = 1'b1;
    bus.MemRD  = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if (bus.MemReq !== 1'b0 || bus.Stall !== 1'b0)
      $display("FAIL idle_ack: got memreq=%b stall=%b expected 0 0", bus.MemReq, bus.Stall); else n_pass++;
    @(posedge clk); #1;
    bus.MemAck = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.MemReq !== 1'b0 || bus.Stall !== 1'b0)
      $display("FAIL idle_ack_after: got memreq=%b stall=%b expected 0 0", bus.MemReq, bus.Stall); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill;
    obs_t o;
    logic [31:0] e;
    int cyc;
    bus.Req = 1'b1; bus.WE = 1'b0; bus.ByteEn = 4'hF; bus.A = 32'h200;
    cyc = 0;
    while (bus.MemReq !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (bus.MemReq !== 1'b1) $display("FAIL mid_fill_start: got memreq=%b expected 1", bus.MemReq); else n_pass++;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    bus.Req = 1'b0;
    #1;
    n_checks++; if (bus.MemReq !== 1'b0 || bus.Stall !== 1'b0 || bus.MemAddr !== 32'h0)
      $display("FAIL async_rst: got memreq=%b stall=%b addr=%h expected 0 0 0", bus.MemReq, bus.Stall, bus.MemAddr); else n_pass++;
    bus.MemAck = 1'b1;
    bus.MemRD  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.MemReq !== 1'b0 || bus.Stall !== 1'b0)
      $display("FAIL late_ack: got memreq=%b stall=%b expected 0 0", bus.MemReq, bus.Stall); else n_pass++;
    @(posedge clk); #1;
    bus.MemAck = 1'b0;
    exp_q.push_back(ref_rd(32'h100));
    do_access(1'b0, 4'hF, 32'h100, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 1 || o.rd !== e)
      $display("FAIL rst_inval_100: got rd=%h memreq=%0d expected %h 1", o.rd, o.mreqs, e); else n_pass++;
    exp_q.push_back(ref_rd(32'h108));
    do_access(1'b0, 4'hF, 32'h108, 32'h0, 1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.timeout || o.mreqs != 1 || o.rd !== e)
      $display("FAIL rst_inval_108: got rd=%h memreq=%0d expected %h 1", o.rd, o.mreqs, e); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    bus.Req = 1'b0; bus.WE = 1'b0; bus.ByteEn = 4'h0; bus.A = '0; bus.WD = '0;
    bus.MemAck = 1'b0; bus.MemRD = '0;
    ref_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h140] = 32'h12345678;
    ref_mem[32'h108] = 32'hCAFEF00D;
    ref_mem[32'h200] = 32'h0BADC0DE;
    test_reset();
    test_cold_fill();
    test_load_hit();
    test_store();
    test_conflict();
    test_back_to_back();
    test_ack_ignored();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: CPU and memory data/address width.
REQ-002 SHALL have parameter SETS, default 16: number of direct-mapped lines, power of two, one word per line.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port Req, input, 1: CPU memory access valid this cycle.
REQ-006 SHALL have port WE, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port ByteEn, input, 4: store byte lanes (4'b1111 SW, one-hot SB).
REQ-008 SHALL have port A, input, DATA_WIDTH: byte address; A[1:0] ignored for line lookup.
REQ-009 SHALL have port WD, input, DATA_WIDTH: store data, lane-aligned.
REQ-010 SHALL have port RD, output, DATA_WIDTH: aligned word to the downstream load formatter.
REQ-011 SHALL have port Stall, output, 1: CPU must hold Req/WE/A/WD/ByteEn while high.
REQ-012 SHALL have ports MemReq (out, 1), MemWE (out, 1), MemAddr (out, DATA_WIDTH), MemWD (out, DATA_WIDTH), MemBE (out, 4), MemAck (in, 1), MemRD (in, DATA_WIDTH): backing-memory handshake.

Function
REQ-013 SHALL split A: index = A[2+log2(SETS)-1:2], tag = remaining upper bits; hit = valid[index] and tag match.
REQ-014 SHALL use FSM states IDLE, FILL, WTHRU.
REQ-015 IDLE, load hit: RD = line data combinationally, same cycle; Stall = 0; no memory traffic.
REQ-016 IDLE, load miss: Stall = 1 same cycle; next state FILL.
REQ-017 FILL: MemReq = 1, MemWE = 0, MemAddr = {A[31:2],2'b00}; Stall = 1; on MemAck, write MemRD into line, set valid, store tag, go IDLE; the held request then hits next cycle.
REQ-018 IDLE, store (hit or miss): Stall = 1; next state WTHRU; no write-allocate.
REQ-019 WTHRU: MemReq = 1, MemWE = 1, MemAddr = A, MemWD = WD, MemBE = ByteEn; Stall = 1 until MemAck; on MemAck, if hit, merge enabled bytes into line; go IDLE; Stall = 0 in the ack cycle.
REQ-020 MemReq, MemAddr, MemWD, MemBE SHALL stay stable until MemAck; MemAck while MemReq = 0 is ignored.
REQ-021 Req = 0 in IDLE: Stall = 0, RD = don't-care, no state change.
REQ-022 RD SHALL be a full word; byte/halfword extraction belongs downstream.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE and clear all valid bits; data/tag arrays not reset.
REQ-024 During/after reset: Stall = 0, MemReq = 0, MemWE = 0; MemAddr/MemWD/MemBE = 0; RD = 0.
REQ-025 Reset mid-FILL/WTHRU SHALL abandon the transfer; a late MemAck SHALL be ignored.

Configuration
REQ-026 With DATA_CACHE_STATS_EN defined, SHALL add outputs HitCount and MissCount (32-bit, reset 0, wrapping) counting IDLE load hits and load misses once each.
REQ-027 Without DATA_CACHE_STATS_EN, those ports and counters SHALL not exist.

Structure
REQ-028 Package data_cache_pkg SHALL hold the FSM state enum and byte-lane width constant.
REQ-029 Tag/data/valid storage SHALL be sub-module data_cache_array (one read port, one byte-enabled write port).

Verification
REQ-030 Load A=0x100 cold, MemAck after 3 cycles with MemRD=0xDEADBEEF -> Stall 4 cycles, then RD=0xDEADBEEF with Stall=0.
REQ-031 Repeat load A=0x100 -> RD=0xDEADBEEF same cycle, MemReq never asserted.
REQ-032 Store A=0x101, ByteEn=4'b0010, WD=0x0000AA00 -> MemWE=1, MemBE=4'b0010; next load 0x100 hits with RD=0xDEADAAEF.
REQ-033 Load A=0x140 (same index as 0x100 for SETS=16, different tag) -> miss, FILL; subsequent load 0x100 misses again.
REQ-034 Assert rst_n low during FILL then MemAck -> state IDLE, all lines invalid, load 0x100 misses.
REQ-035 With DATA_CACHE_STATS_EN, sequence REQ-030..031 -> MissCount=1, HitCount=1.
